// File: rtl/pe_cfg_pkg.sv
// rtl/pe_cfg_pkg.sv - shared types and constants for pe_cfg_loader; CFG_CHECKSUM_EN adds the CHECK state
`ifndef INST_SIZE
`define INST_SIZE 32
`endif

package pe_cfg_pkg;

    localparam int SLOTS_PER_PE = 2;

    // The header length field starts at bit 0 and is one bit wider than a slot address,
    // so a full image (NUM_PE*2 words) is representable.
    localparam int HDR_LSB     = 0;
    localparam int HDR_EXTRA_W = 1;

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } cfg_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd3
    } cfg_state_t;
`endif

endpackage

// File: rtl/cfg_checksum.sv
// rtl/cfg_checksum.sv - clear/enable XOR accumulator over the loaded instruction words
module cfg_checksum
    import pe_cfg_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

endmodule

// File: rtl/pe_cfg_loader.sv
// rtl/pe_cfg_loader.sv - streams a header plus N instruction words into PE slots; CFG_CHECKSUM_EN adds checksum verify
module pe_cfg_loader
    import pe_cfg_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int INST_W = `INST_SIZE,
    parameter int ADDR_W = $clog2(NUM_PE * SLOTS_PER_PE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inWord,
    input  logic              inValid,
    output logic              inReady,
    output logic              cfgWe,
    output logic [ADDR_W-1:0] cfgAddr,
    output logic [INST_W-1:0] cfgInst,
    output logic              arrayRun,
    output logic              busy,
    output logic              cfgErr
);

    localparam int               HDR_W = ADDR_W + HDR_EXTRA_W;
    localparam logic [HDR_W-1:0] MAX_N = HDR_W'(NUM_PE * SLOTS_PER_PE);

    cfg_state_t        state;
    cfg_state_t        state_n;
    logic [HDR_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic              accept;
    logic [HDR_W-1:0]  hdr_n;
    logic              hdr_zero;
    logic              hdr_big;
    logic              last_word;

    assign accept    = inValid & inReady;
    assign hdr_n     = inWord[HDR_LSB +: HDR_W];
    assign hdr_zero  = (hdr_n == '0);
    assign hdr_big   = (hdr_n > MAX_N);
    assign last_word = (cnt == HDR_W'(1));

`ifdef CFG_CHECKSUM_EN
    logic [INST_W-1:0] acc;
    logic              sum_ok;

    cfg_checksum #(.W(INST_W)) u_checksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept && (state == IDLE || state == RUN)),
        .en   (accept && (state == LOAD)),
        .data (inWord),
        .acc  (acc)
    );

    assign sum_ok = (inWord == acc);
    assign busy   = (state == LOAD) || (state == CHECK);
`else
    assign busy   = (state == LOAD);
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    if (hdr_zero) state_n = RUN;
                    else if (hdr_big) state_n = IDLE;
                    else state_n = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_word) begin
`ifdef CFG_CHECKSUM_EN
                    state_n = CHECK;
`else
                    state_n = RUN;
`endif
                end
            end
`ifdef CFG_CHECKSUM_EN
            CHECK: begin
                if (accept) state_n = sum_ok ? RUN : IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            flush    <= 1'b0;
            inReady  <= 1'b0;
            cfgWe    <= 1'b0;
            cfgAddr  <= '0;
            cfgInst  <= '0;
            arrayRun <= 1'b0;
            cfgErr   <= 1'b0;
        end else begin
            state   <= state_n;
            inReady <= 1'b1;
            cfgWe   <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        cfgErr   <= hdr_big;
                        arrayRun <= 1'b0;
                        flush    <= 1'b0;
                        cnt      <= hdr_n;
                        addr     <= '0;
                    end else if (state == RUN) begin
                        // One flush cycle after the last write lets the PEs sample it first.
                        if (flush) flush <= 1'b0;
                        else arrayRun <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cfgWe   <= 1'b1;
                        cfgAddr <= addr;
                        cfgInst <= inWord;
                        addr    <= addr + 1'b1;
                        cnt     <= cnt - 1'b1;
`ifndef CFG_CHECKSUM_EN
                        flush   <= last_word;
`endif
                    end
                end
`ifdef CFG_CHECKSUM_EN
                CHECK: begin
                    if (accept && !sum_ok) cfgErr <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
